// File: rtl/spi_frame_tx.sv
// Multi-channel SPI mode-0 master: streams NUM_CH samples of DATA_W bits per chip-select frame.
// Latency: first bit on mosi and ncs low at the start edge; frame lasts 2*N*CLK_DIV clks, then GAP_CYC clks gap.
// Backpressure: none; start is honoured only in IDLE (ignored while busy), cont re-arms at end of gap.
module spi_frame_tx #(
  parameter int DATA_W    = 10,
  parameter int NUM_CH    = 4,
  parameter int CLK_DIV   = 4,
  parameter int GAP_CYC   = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     cont,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  output logic                     busy,
  output logic                     done,
  output logic                     sclk,
  output logic                     mosi,
  output logic                     ncs
);

  localparam int N     = NUM_CH * DATA_W;
  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int BIT_W = $clog2(N + 1);
  localparam int GAP_W = $clog2(GAP_CYC + 1);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(N - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  state_t           state;
  logic [N-1:0]     ordered;   // frame bits in transmit order, first bit at MSB
  logic [N-1:0]     sreg;      // bits still to be sent after the one on mosi
  logic [DIV_W-1:0] div_cnt;
  logic [BIT_W-1:0] bit_cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic             launch;

  // Reorder the sample bus into transmit order: channel 0 first, bit order per MSB_FIRST.
  always_comb begin
    ordered = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      for (int b = 0; b < DATA_W; b++) begin
        if (MSB_FIRST)
          ordered[N-1-(c*DATA_W+b)] = ch_data[c*DATA_W+DATA_W-1-b];
        else
          ordered[N-1-(c*DATA_W+b)] = ch_data[c*DATA_W+b];
      end
    end
  end

  // A frame starts from IDLE on start, or back-to-back at the last gap cycle in continuous mode.
  always_comb begin
    launch = 1'b0;
    if (state == IDLE && start)
      launch = 1'b1;
    else if (state == GAP && gap_cnt == GAP_LAST && cont)
      launch = 1'b1;
  end

  // Frame sequencer: snapshot, sclk generation, bit shifting, end-of-frame and gap timing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      sreg    <= '0;
      div_cnt <= '0;
      bit_cnt <= '0;
      gap_cnt <= '0;
      sclk    <= 1'b0;
      mosi    <= 1'b0;
      ncs     <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (launch) begin
        state   <= SHIFT;
        sreg    <= ordered << 1;
        mosi    <= ordered[N-1];
        ncs     <= 1'b0;
        busy    <= 1'b1;
        sclk    <= 1'b0;
        div_cnt <= '0;
        bit_cnt <= '0;
      end else begin
        case (state)
          SHIFT: begin
            if (div_cnt == DIV_LAST) begin
              div_cnt <= '0;
              if (!sclk) begin
                sclk <= 1'b1;
              end else begin
                // Falling edge: either advance to the next bit or close the frame.
                sclk <= 1'b0;
                if (bit_cnt == BIT_LAST) begin
                  state   <= GAP;
                  gap_cnt <= '0;
                  ncs     <= 1'b1;
                  mosi    <= 1'b0;
                  done    <= 1'b1;
                end else begin
                  bit_cnt <= bit_cnt + 1'b1;
                  mosi    <= sreg[N-1];
                  sreg    <= sreg << 1;
                end
              end
            end else begin
              div_cnt <= div_cnt + 1'b1;
            end
          end
          GAP: begin
            if (gap_cnt == GAP_LAST) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              gap_cnt <= gap_cnt + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_frame_tx.sv
// Directed bench for spi_frame_tx: main (MSB-first), LSB-first and minimum-size instances.
// Latency: stimulus applied at negedge, outputs observed at negedge.
// Backpressure: not applicable; start ignored while busy is exercised directly.
module tb_spi_frame_tx;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        start0 = 1'b0, start1 = 1'b0, start2 = 1'b0, cont0 = 1'b0;
  logic [19:0] d0 = '0, d1 = '0;
  logic [0:0]  d2 = '0;
  logic busy0, done0, sclk0, mosi0, ncs0;
  logic busy1, done1, sclk1, mosi1, ncs1;
  logic busy2, done2, sclk2, mosi2, ncs2;

  spi_frame_tx #(.DATA_W(10), .NUM_CH(2), .CLK_DIV(2), .GAP_CYC(4), .MSB_FIRST(1'b1)) u_main (
    .clk(clk), .reset(reset), .start(start0), .cont(cont0), .ch_data(d0),
    .busy(busy0), .done(done0), .sclk(sclk0), .mosi(mosi0), .ncs(ncs0));

  spi_frame_tx #(.DATA_W(10), .NUM_CH(2), .CLK_DIV(2), .GAP_CYC(4), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .reset(reset), .start(start1), .cont(1'b0), .ch_data(d1),
    .busy(busy1), .done(done1), .sclk(sclk1), .mosi(mosi1), .ncs(ncs1));

  spi_frame_tx #(.DATA_W(1), .NUM_CH(1), .CLK_DIV(2), .GAP_CYC(1), .MSB_FIRST(1'b1)) u_min (
    .clk(clk), .reset(reset), .start(start2), .cont(1'b0), .ch_data(d2),
    .busy(busy2), .done(done2), .sclk(sclk2), .mosi(mosi2), .ncs(ncs2));

  // Observed instance selected by sel.
  int   sel = 0;
  logic m_sclk, m_mosi, m_ncs, m_busy, m_done;
  always_comb begin
    case (sel)
      1:       {m_sclk, m_mosi, m_ncs, m_busy, m_done} = {sclk1, mosi1, ncs1, busy1, done1};
      2:       {m_sclk, m_mosi, m_ncs, m_busy, m_done} = {sclk2, mosi2, ncs2, busy2, done2};
      default: {m_sclk, m_mosi, m_ncs, m_busy, m_done} = {sclk0, mosi0, ncs0, busy0, done0};
    endcase
  end

  int checks = 0, errors = 0;
  int rises, ncs_low, dones, ncs_falls, busy_falls, viol, misalign;
  int cyc = 0, t_rise, busy_gap, gap_min, gap_max;
  bit have_rise;
  logic [31:0] bits;
  logic p_sclk, p_mosi, p_ncs, p_busy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    rises = 0; ncs_low = 0; dones = 0; ncs_falls = 0; busy_falls = 0;
    viol = 0; misalign = 0; busy_gap = -1; gap_min = 9999; gap_max = -1;
    have_rise = 1'b0; t_rise = 0; bits = '0;
    p_sclk = m_sclk; p_mosi = m_mosi; p_ncs = m_ncs; p_busy = m_busy;
  endtask

  // Sample the selected instance for n cycles, accumulating frame statistics.
  task automatic watch(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cyc++;
      if (m_sclk && !p_sclk) begin
        rises++;
        bits = {bits[30:0], m_mosi};
      end
      if (!m_ncs) ncs_low++;
      if (m_done) dones++;
      if (m_done && !(m_ncs && !p_ncs)) misalign++;
      if (m_ncs && !p_ncs) begin
        t_rise = cyc;
        have_rise = 1'b1;
        if (!m_done) misalign++;
      end
      if (!m_ncs && p_ncs) begin
        ncs_falls++;
        if (have_rise) begin
          if (cyc - t_rise < gap_min) gap_min = cyc - t_rise;
          if (cyc - t_rise > gap_max) gap_max = cyc - t_rise;
        end
      end
      if (!m_busy && p_busy) begin
        busy_falls++;
        busy_gap = cyc - t_rise;
      end
      if (m_mosi !== p_mosi && !(p_sclk && !m_sclk) && (m_ncs == p_ncs)) viol++;
      if (m_sclk && m_ncs) viol++;
      p_sclk = m_sclk; p_mosi = m_mosi; p_ncs = m_ncs; p_busy = m_busy;
    end
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_main", 32'({sclk0, ncs0, mosi0, busy0, done0}), 32'b01000);
    chk("reset_min",  32'({sclk2, ncs2, mosi2, busy2, done2}), 32'b01000);
    reset = 1'b0;
    watch(2);

    // Basic frame, MSB first
    sel = 0; d0 = {10'h155, 10'h3C0}; clr();
    start0 = 1'b1; watch(1); start0 = 1'b0; watch(120);
    chk("basic_rises", 32'(rises), 32'd20);
    chk("basic_bits", 32'(bits[19:0]), 32'({10'h3C0, 10'h155}));
    chk("basic_ncs_low", 32'(ncs_low), 32'd80);
    chk("basic_done", 32'(dones), 32'd1);
    chk("basic_busy_gap", 32'(busy_gap), 32'd4);
    chk("basic_align_viol", 32'(misalign + viol), 32'd0);
    chk("basic_idle", 32'({sclk0, ncs0, mosi0, busy0}), 32'b0100);

    // Ignored start and snapshot
    d0 = {10'h2AA, 10'h0F3}; clr();
    start0 = 1'b1; watch(1); start0 = 1'b0; watch(20);
    start0 = 1'b1; d0 = {10'h015, 10'h3FF}; watch(1); start0 = 1'b0; watch(120);
    chk("snap_rises", 32'(rises), 32'd20);
    chk("snap_bits", 32'(bits[19:0]), 32'({10'h0F3, 10'h2AA}));
    chk("snap_frames", 32'(ncs_falls), 32'd1);
    chk("snap_done", 32'(dones), 32'd1);

    // Continuous mode, cont dropped during frame 3
    d0 = {10'h0C3, 10'h21E}; cont0 = 1'b1; clr();
    start0 = 1'b1; watch(1); start0 = 1'b0; watch(200);
    cont0 = 1'b0; watch(150);
    chk("cont_frames", 32'(ncs_falls), 32'd3);
    chk("cont_done", 32'(dones), 32'd3);
    chk("cont_rises", 32'(rises), 32'd60);
    chk("cont_ncs_low", 32'(ncs_low), 32'd240);
    chk("cont_gap_min", 32'(gap_min), 32'd4);
    chk("cont_gap_max", 32'(gap_max), 32'd4);
    chk("cont_busy_falls", 32'(busy_falls), 32'd1);
    chk("cont_busy_gap", 32'(busy_gap), 32'd4);
    chk("cont_bits", 32'(bits[19:0]), 32'({10'h21E, 10'h0C3}));
    chk("cont_align_viol", 32'(misalign + viol), 32'd0);

    // Reset mid-frame
    d0 = {10'h1A5, 10'h05A}; clr();
    start0 = 1'b1; watch(1); start0 = 1'b0; watch(29);
    chk("rst_inframe_ncs", 32'(ncs0), 32'd0);
    #2 reset = 1'b1; start0 = 1'b1;
    #1 chk("rst_async", 32'({sclk0, ncs0, mosi0, busy0, done0}), 32'b01000);
    @(negedge clk); clr(); watch(3);
    chk("rst_hold_quiet", 32'(rises + dones), 32'd0);
    reset = 1'b0; clr();
    watch(1); start0 = 1'b0; watch(100);
    chk("rst_new_rises", 32'(rises), 32'd20);
    chk("rst_new_bits", 32'(bits[19:0]), 32'({10'h05A, 10'h1A5}));
    chk("rst_new_done", 32'(dones), 32'd1);

    // LSB-first instance
    sel = 1; d1 = {10'h200, 10'h001}; clr();
    start1 = 1'b1; watch(1); start1 = 1'b0; watch(100);
    chk("lsb_rises", 32'(rises), 32'd20);
    chk("lsb_bits", 32'(bits[19:0]), 32'h80001);
    chk("lsb_done", 32'(dones), 32'd1);

    // Minimum-size instance
    sel = 2; d2 = 1'b1; clr();
    start2 = 1'b1; watch(1); start2 = 1'b0; watch(20);
    chk("min_rises", 32'(rises), 32'd1);
    chk("min_bit", 32'(bits[0]), 32'd1);
    chk("min_ncs_low", 32'(ncs_low), 32'd4);
    chk("min_done", 32'(dones), 32'd1);
    chk("min_busy_gap", 32'(busy_gap), 32'd1);
    chk("min_align_viol", 32'(misalign + viol), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_frame_tx.md
Name: spi_frame_tx

Overview:
- Parametrised, multi-channel SPI master transmitter that streams a frame of NUM_CH samples, each DATA_W bits, to the Raspberry Pi over one chip-select frame.
- Successor to the single-channel 10-bit voltage sender. Adds:
  - an internally generated sclk from the system clock;
  - configurable bit order;
  - a guaranteed inter-frame gap;
  - busy/done handshake;
  - continuous (auto-repeat) mode.
- Sits between the sample-capture logic and the FPGA pins driving the Pi SPI slave.

Parameters:
- DATA_W, 10, bits per channel sample (≥1).
- NUM_CH, 4, channels per frame (≥1); channel 0 is transmitted first.
- CLK_DIV, 4, clk cycles per sclk half-period (≥2).
- GAP_CYC, 8, clk cycles ncs held high after a frame before the next frame may start (≥1).
- MSB_FIRST, 1, 1 = each sample MSB first; 0 = LSB first.

Ports:
- clk, input, 1, system clock; all logic on rising edge.
- reset, input, 1, asynchronous, active-high.
- start, input, 1, frame request; sampled only in IDLE (level, not edge).
- cont, input, 1, continuous mode; sampled at end of GAP.
- ch_data, input, NUM_CH*DATA_W, samples; channel i occupies bits [i*DATA_W +: DATA_W].
- busy, output, 1, high from frame start through end of GAP.
- done, output, 1, one-clk pulse when a frame completes.
- sclk, output, 1, SPI clock, idle low (mode 0).
- mosi, output, 1, SPI data.
- ncs, output, 1, chip select, active low.

Behaviour:
- Reset (async, any state): go to IDLE. Outputs: sclk=0, mosi=0, ncs=1, busy=0, done=0. Shift register, divider and bit counter are cleared. A frame in flight is abandoned and no done is issued.
- States: IDLE, SHIFT, GAP.
- IDLE:
  - Outputs sclk=0, ncs=1, mosi=0, busy=0.
  - If start=1 at clk edge t0: snapshot all of ch_data into the frame shift register and enter SHIFT.
  - At that same edge: ncs<=0, busy<=1, mosi<=first bit (channel 0, MSB or LSB per MSB_FIRST).
- Frame timing:
  - N = NUM_CH*DATA_W bits per frame.
  - Bit k (0-based) is driven from edge t0+2k*CLK_DIV.
  - sclk rises at t0+(2k+1)*CLK_DIV and falls at t0+(2k+2)*CLK_DIV.
  - mosi changes only coincident with sclk falling, or at t0. It is stable across every rising edge (mode 0: Pi samples on rise).
- Frame end:
  - At the falling edge of bit N-1 (edge t0+2N*CLK_DIV): sclk<=0, ncs<=1, mosi<=0, done<=1 for exactly one clk, enter GAP.
  - ncs is low for exactly 2N*CLK_DIV clk cycles.
  - Exactly N rising sclk edges per frame.
- GAP:
  - busy stays 1, ncs=1, sclk=0; lasts GAP_CYC clk cycles.
  - On the last GAP cycle, if cont=1: re-snapshot ch_data and start a new frame directly, with identical timing (that edge acts as t0).
  - Otherwise enter IDLE and busy<=0.
- start while busy (SHIFT or GAP) is ignored, not queued. start held high in IDLE starts a frame every time IDLE is reached.
- ch_data changes during SHIFT have no effect on the current frame (snapshot only).
- Bit order within a sample follows MSB_FIRST. Channel order is always 0..NUM_CH-1.
- Counters:
  - Divider width is $clog2(CLK_DIV); it wraps at CLK_DIV-1.
  - Bit counter width is $clog2(N+1).
  - Gap counter width is $clog2(GAP_CYC+1).
  - No counter may wrap inside a frame.
- done and busy are registered outputs. sclk, ncs and mosi are registered, so there is no combinational path from inputs to pins.

Test Plan:
- Use DATA_W=10, NUM_CH=2, CLK_DIV=2, GAP_CYC=4, MSB_FIRST=1 unless stated.
- Basic frame: ch_data={10'h155, 10'h3C0}, start pulse 1 clk → ncs low for 80 clk cycles, exactly 20 sclk rises. mosi sampled at rises = 1111000000 0101010101 (ch0=0x3C0 first). done pulses once at ncs rise. busy falls 4 clks later.
- LSB-first build (MSB_FIRST=0), ch0=10'h001, ch1=10'h200 → first sampled bit 1, bits 1–18 are 0, bit 19 is 1.
- Ignored start / snapshot: pulse start again at bit 5 and change ch_data mid-frame → only one frame (20 rises), transmitted data equals the t0 snapshot, second start has no effect.
- Continuous: cont=1, one start → back-to-back frames with ncs high for exactly 4 clks between them, done each frame, busy never drops. Drop cont during frame 3 → busy falls after frame 3's GAP.
- Reset mid-frame: assert reset at bit 7 → sclk=0, ncs=1, mosi=0, busy=0 immediately (asynchronously), no done. After release with start=1, a fresh full 20-bit frame begins with bit 0.
- Minimum config DATA_W=1, NUM_CH=1, CLK_DIV=2 → ncs low 4 clks, one sclk pulse, done one clk.
